// File: rtl/wb_retire_unit.sv
// wb_retire_unit
//   Collects writeback results from NUM_CH channels that may complete out of order. Results
//   are parked in a DEPTH-entry window indexed by sequence tag. The unit retires one result
//   per cycle in program order toward the register file and the perf counters.
//
// Ports
//   clk, reset         clock; asynchronous active-low reset
//   wb_valid/tag/...   per-channel result offer (packed NUM_CH-wide buses)
//   wb_ready           per-channel accept, combinational
//   flush, flush_tag   drop the whole window and restart at flush_tag
//   ret_*              registered retire port (tag, register write, value)
//   retired_cnt/branch_cnt/hit_cnt   free-running perf counters
//   dup_err            sticky: an offer hit a slot that was already occupied
module wb_retire_unit #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned DBITS     = 32,
    parameter int unsigned REGNOBITS = 5,
    parameter int unsigned TAGW      = $clog2(DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CH-1:0]             wb_valid,
    input  logic [NUM_CH*TAGW-1:0]        wb_tag,
    input  logic [NUM_CH-1:0]             wb_wr_reg,
    input  logic [NUM_CH*REGNOBITS-1:0]   wb_rd,
    input  logic [NUM_CH*DBITS-1:0]       wb_value,
    input  logic [NUM_CH-1:0]             wb_is_br,
    input  logic [NUM_CH-1:0]             wb_br_hit,
    output logic [NUM_CH-1:0]             wb_ready,
    input  logic                          flush,
    input  logic [TAGW-1:0]               flush_tag,
    output logic                          ret_valid,
    output logic [TAGW-1:0]               ret_tag,
    output logic                          ret_wr_reg,
    output logic [REGNOBITS-1:0]          ret_rd,
    output logic [DBITS-1:0]              ret_value,
    output logic [DBITS-1:0]              retired_cnt,
    output logic [DBITS-1:0]              branch_cnt,
    output logic [DBITS-1:0]              hit_cnt,
    output logic                          dup_err
);

    localparam int unsigned SLOTW = TAGW - 1;

    // Window state
    logic [TAGW-1:0]      head_q, head_d;
    logic [DEPTH-1:0]     slot_valid_q, slot_valid_d;

    // Entry payload; only meaningful while the matching valid bit is set, so no reset
    logic [DEPTH-1:0]     slot_wr_q;
    logic [DEPTH-1:0]     slot_br_q;
    logic [DEPTH-1:0]     slot_hit_q;
    logic [REGNOBITS-1:0] slot_rd_q    [DEPTH];
    logic [DBITS-1:0]     slot_value_q [DEPTH];

    // Per-channel decode
    logic [TAGW-1:0]      ch_tag  [NUM_CH];
    logic [TAGW-1:0]      ch_off  [NUM_CH];
    logic [SLOTW-1:0]     ch_slot [NUM_CH];
    logic [NUM_CH-1:0]    ch_live;
    logic [NUM_CH-1:0]    ch_dup;
    logic [NUM_CH-1:0]    ch_blocked;

    logic [SLOTW-1:0]     head_slot;
    logic                 retire;

    always_comb begin
        ch_live    = '0;
        ch_dup     = '0;
        ch_blocked = '0;
        wb_ready   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_tag[c]  = wb_tag[c*TAGW +: TAGW];
            ch_off[c]  = ch_tag[c] - head_q;
            ch_slot[c] = ch_tag[c][SLOTW-1:0];
            // DEPTH == 2^(TAGW-1), so offset < DEPTH is simply a clear offset MSB
            ch_live[c] = wb_valid[c] & ~ch_off[c][TAGW-1];
            ch_dup[c]  = ch_live[c] & slot_valid_q[ch_slot[c]];
        end
        for (int c = 0; c < NUM_CH; c++) begin
            // Any lower live channel on the same slot wins, even if it is itself refused
            for (int j = 0; j < NUM_CH; j++) begin
                if (j < c && ch_live[j] && ch_slot[j] == ch_slot[c]) begin
                    ch_blocked[c] = 1'b1;
                end
            end
            wb_ready[c] = ch_live[c] & ~slot_valid_q[ch_slot[c]] & ~flush & ~ch_blocked[c];
        end
    end

    assign head_slot = head_q[SLOTW-1:0];
    assign retire    = slot_valid_q[head_slot] & ~flush;

    always_comb begin
        slot_valid_d = slot_valid_q;
        head_d       = head_q;
        if (flush) begin
            slot_valid_d = '0;
            head_d       = flush_tag;
        end else begin
            // A write never targets a valid slot, so clearing the head and setting
            // newly accepted slots cannot collide; a fresh head write waits a cycle.
            if (retire) begin
                slot_valid_d[head_slot] = 1'b0;
                head_d                  = head_q + TAGW'(1);
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (wb_ready[c]) begin
                    slot_valid_d[ch_slot[c]] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (wb_ready[c]) begin
                slot_wr_q[ch_slot[c]]    <= wb_wr_reg[c];
                slot_br_q[ch_slot[c]]    <= wb_is_br[c];
                slot_hit_q[ch_slot[c]]   <= wb_br_hit[c];
                slot_rd_q[ch_slot[c]]    <= wb_rd[c*REGNOBITS +: REGNOBITS];
                slot_value_q[ch_slot[c]] <= wb_value[c*DBITS +: DBITS];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q       <= '0;
            slot_valid_q <= '0;
            ret_valid    <= 1'b0;
            ret_tag      <= '0;
            ret_wr_reg   <= 1'b0;
            ret_rd       <= '0;
            ret_value    <= '0;
            retired_cnt  <= '0;
            branch_cnt   <= '0;
            hit_cnt      <= '0;
            dup_err      <= 1'b0;
        end else begin
            head_q       <= head_d;
            slot_valid_q <= slot_valid_d;
            dup_err      <= dup_err | (|ch_dup);
            if (retire) begin
                ret_valid   <= 1'b1;
                ret_tag     <= head_q;
                ret_wr_reg  <= slot_wr_q[head_slot];
                ret_rd      <= slot_rd_q[head_slot];
                ret_value   <= slot_value_q[head_slot];
                retired_cnt <= retired_cnt + DBITS'(1);
                if (slot_br_q[head_slot]) begin
                    branch_cnt <= branch_cnt + DBITS'(1);
                end
                if (slot_br_q[head_slot] && slot_hit_q[head_slot]) begin
                    hit_cnt <= hit_cnt + DBITS'(1);
                end
            end else begin
                // Data outputs hold their last retired value
                ret_valid  <= 1'b0;
                ret_wr_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_retire_unit.sv
module tb_wb_retire_unit;

    localparam int NUM_CH    = 2;
    localparam int DEPTH     = 8;
    localparam int DBITS     = 32;
    localparam int REGNOBITS = 5;
    localparam int TAGW      = 4;

    logic                        clk;
    logic                        reset;
    logic [NUM_CH-1:0]           wb_valid;
    logic [NUM_CH*TAGW-1:0]      wb_tag;
    logic [NUM_CH-1:0]           wb_wr_reg;
    logic [NUM_CH*REGNOBITS-1:0] wb_rd;
    logic [NUM_CH*DBITS-1:0]     wb_value;
    logic [NUM_CH-1:0]           wb_is_br;
    logic [NUM_CH-1:0]           wb_br_hit;
    logic [NUM_CH-1:0]           wb_ready;
    logic                        flush;
    logic [TAGW-1:0]             flush_tag;
    logic                        ret_valid;
    logic [TAGW-1:0]             ret_tag;
    logic                        ret_wr_reg;
    logic [REGNOBITS-1:0]        ret_rd;
    logic [DBITS-1:0]            ret_value;
    logic [DBITS-1:0]            retired_cnt;
    logic [DBITS-1:0]            branch_cnt;
    logic [DBITS-1:0]            hit_cnt;
    logic                        dup_err;

    int n_cmp = 0;
    int n_bad = 0;

    wb_retire_unit #(
        .NUM_CH(NUM_CH), .DEPTH(DEPTH), .DBITS(DBITS), .REGNOBITS(REGNOBITS), .TAGW(TAGW)
    ) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_wr_reg(wb_wr_reg), .wb_rd(wb_rd),
        .wb_value(wb_value), .wb_is_br(wb_is_br), .wb_br_hit(wb_br_hit), .wb_ready(wb_ready),
        .flush(flush), .flush_tag(flush_tag),
        .ret_valid(ret_valid), .ret_tag(ret_tag), .ret_wr_reg(ret_wr_reg), .ret_rd(ret_rd),
        .ret_value(ret_value), .retired_cnt(retired_cnt), .branch_cnt(branch_cnt),
        .hit_cnt(hit_cnt), .dup_err(dup_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_offers();
        wb_valid  = '0;
        wb_tag    = '0;
        wb_wr_reg = '0;
        wb_rd     = '0;
        wb_value  = '0;
        wb_is_br  = '0;
        wb_br_hit = '0;
    endtask

    task automatic offer(input int ch, input int tag, input logic wr, input int rd,
                         input logic [31:0] val, input logic br, input logic hit);
        wb_valid[ch]                       = 1'b1;
        wb_tag[ch*TAGW +: TAGW]            = tag[TAGW-1:0];
        wb_wr_reg[ch]                      = wr;
        wb_rd[ch*REGNOBITS +: REGNOBITS]   = rd[REGNOBITS-1:0];
        wb_value[ch*DBITS +: DBITS]        = val;
        wb_is_br[ch]                       = br;
        wb_br_hit[ch]                      = hit;
    endtask

    task automatic do_reset();
        clear_offers();
        flush     = 1'b0;
        flush_tag = '0;
        reset     = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (ret_valid !== 1'b0) begin n_bad++; $display("FAIL rst_ret_valid: got %b want 0", ret_valid); end
        n_cmp++; if (ret_tag !== 4'd0) begin n_bad++; $display("FAIL rst_ret_tag: got %h want 0", ret_tag); end
        n_cmp++; if (ret_value !== 32'd0) begin n_bad++; $display("FAIL rst_ret_value: got %h want 0", ret_value); end
        n_cmp++; if (retired_cnt !== 32'd0) begin n_bad++; $display("FAIL rst_retired_cnt: got %0d want 0", retired_cnt); end
        n_cmp++; if (dup_err !== 1'b0) begin n_bad++; $display("FAIL rst_dup_err: got %b want 0", dup_err); end
        reset = 1'b1;
    endtask

    // ch0 tags 0,1,2 on consecutive cycles retire in cycles 2,3,4
    task automatic test_in_order();
        logic exp_v;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp_v = (i >= 2 && i <= 4);
            n_cmp++; if (ret_valid !== exp_v) begin n_bad++; $display("FAIL inorder_valid[%0d]: got %b want %b", i, ret_valid, exp_v); end
            if (exp_v) begin
                n_cmp++; if (ret_tag !== 4'(i - 2)) begin n_bad++; $display("FAIL inorder_tag[%0d]: got %0d want %0d", i, ret_tag, i - 2); end
                n_cmp++; if (ret_value !== 32'(32'h100 + i - 2)) begin n_bad++; $display("FAIL inorder_value[%0d]: got %h want %h", i, ret_value, 32'h100 + i - 2); end
            end
            clear_offers();
            if (i < 3) begin
                offer(0, i, 1'b1, i + 1, 32'h100 + i, 1'b0, 1'b0);
                #1;
                n_cmp++; if (wb_ready !== 2'b01) begin n_bad++; $display("FAIL inorder_ready[%0d]: got %b want 01", i, wb_ready); end
            end
        end
        n_cmp++; if (retired_cnt !== 32'd3) begin n_bad++; $display("FAIL inorder_cnt: got %0d want 3", retired_cnt); end
    endtask

    task automatic test_out_of_order();
        do_reset();
        @(negedge clk);
        offer(1, 1, 1'b1, 2, 32'hB, 1'b0, 1'b0);
        #1;
        n_cmp++; if (wb_ready !== 2'b10) begin n_bad++; $display("FAIL ooo_ready0: got %b want 10", wb_ready); end
        @(negedge clk);
        clear_offers();
        offer(0, 0, 1'b1, 1, 32'hA, 1'b0, 1'b0);
        #1;
        n_cmp++; if (wb_ready !== 2'b01) begin n_bad++; $display("FAIL ooo_ready1: got %b want 01", wb_ready); end
        @(negedge clk);
        clear_offers();
        n_cmp++; if (ret_valid !== 1'b0) begin n_bad++; $display("FAIL ooo_valid2: got %b want 0", ret_valid); end
        @(negedge clk);
        n_cmp++; if (ret_valid !== 1'b1 || ret_value !== 32'hA || ret_tag !== 4'd0) begin n_bad++; $display("FAIL ooo_ret3: got v=%b val=%h tag=%0d want v=1 val=a tag=0", ret_valid, ret_value, ret_tag); end
        @(negedge clk);
        n_cmp++; if (ret_valid !== 1'b1 || ret_value !== 32'hB || ret_tag !== 4'd1) begin n_bad++; $display("FAIL ooo_ret4: got v=%b val=%h tag=%0d want v=1 val=b tag=1", ret_valid, ret_value, ret_tag); end
        @(negedge clk);
        n_cmp++; if (ret_valid !== 1'b0) begin n_bad++; $display("FAIL ooo_valid5: got %b want 0", ret_valid); end
    endtask

    task automatic test_collision();
        do_reset();
        @(negedge clk);
        flush = 1'b1; flush_tag = 4'd3;
        offer(0, 0, 1'b1, 1, 32'h1, 1'b0, 1'b0);
        #1;
        n_cmp++; if (wb_ready !== 2'b00) begin n_bad++; $display("FAIL flush_blocks_ready: got %b want 00", wb_ready); end
        @(negedge clk);
        flush = 1'b0;
        clear_offers();
        offer(0, 3, 1'b1, 3, 32'h30, 1'b0, 1'b0);
        offer(1, 3, 1'b1, 4, 32'h31, 1'b0, 1'b0);
        #1;
        n_cmp++; if (wb_ready !== 2'b01) begin n_bad++; $display("FAIL coll_ready: got %b want 01", wb_ready); end
        @(negedge clk);
        n_cmp++; if (dup_err !== 1'b0) begin n_bad++; $display("FAIL coll_dup_early: got %b want 0", dup_err); end
        clear_offers();
        offer(1, 3, 1'b1, 4, 32'h31, 1'b0, 1'b0);
        #1;
        n_cmp++; if (wb_ready !== 2'b00) begin n_bad++; $display("FAIL dup_ready: got %b want 00", wb_ready); end
        @(negedge clk);
        clear_offers();
        n_cmp++; if (dup_err !== 1'b1) begin n_bad++; $display("FAIL dup_set: got %b want 1", dup_err); end
        n_cmp++; if (ret_valid !== 1'b1 || ret_tag !== 4'd3 || ret_value !== 32'h30) begin n_bad++; $display("FAIL coll_ret: got v=%b tag=%0d val=%h want v=1 tag=3 val=30", ret_valid, ret_tag, ret_value); end
        @(negedge clk);
        flush = 1'b1; flush_tag = 4'd0;
        @(negedge clk);
        flush = 1'b0;
        n_cmp++; if (dup_err !== 1'b1) begin n_bad++; $display("FAIL dup_sticky: got %b want 1", dup_err); end
    endtask

    task automatic test_wrap();
        do_reset();
        @(negedge clk);
        flush = 1'b1; flush_tag = 4'd14;
        @(negedge clk);
        flush = 1'b0;
        offer(0, 5, 1'b1, 5, 32'h55, 1'b0, 1'b0);
        offer(1, 6, 1'b1, 6, 32'h66, 1'b0, 1'b0);
        #1;
        n_cmp++; if (wb_ready !== 2'b01) begin n_bad++; $display("FAIL wrap_edge_ready: got %b want 01", wb_ready); end
        @(negedge clk);
        clear_offers();
        offer(0, 14, 1'b1, 14, 32'hE, 1'b0, 1'b0);
        offer(1, 6, 1'b1, 6, 32'h66, 1'b0, 1'b0);
        #1;
        n_cmp++; if (wb_ready !== 2'b01) begin n_bad++; $display("FAIL wrap_head14_ready: got %b want 01", wb_ready); end
        @(negedge clk);
        clear_offers();
        offer(1, 6, 1'b1, 6, 32'h66, 1'b0, 1'b0);
        #1;
        n_cmp++; if (wb_ready !== 2'b00) begin n_bad++; $display("FAIL wrap_hold_ready: got %b want 00", wb_ready); end
        @(negedge clk);
        n_cmp++; if (ret_valid !== 1'b1 || ret_tag !== 4'd14) begin n_bad++; $display("FAIL wrap_ret14: got v=%b tag=%0d want v=1 tag=14", ret_valid, ret_tag); end
        #1;
        n_cmp++; if (wb_ready !== 2'b10) begin n_bad++; $display("FAIL wrap_head15_ready: got %b want 10", wb_ready); end
        @(negedge clk);
        clear_offers();
        offer(0, 15, 1'b1, 15, 32'hF, 1'b0, 1'b0);
        n_cmp++; if (ret_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_idle: got %b want 0", ret_valid); end
        @(negedge clk);
        clear_offers();
        @(negedge clk);
        n_cmp++; if (ret_valid !== 1'b1 || ret_tag !== 4'd15 || ret_value !== 32'hF) begin n_bad++; $display("FAIL wrap_ret15: got v=%b tag=%0d val=%h want v=1 tag=15 val=f", ret_valid, ret_tag, ret_value); end
    endtask

    task automatic test_branches();
        logic [5:0] br_pat;
        logic [5:0] hit_pat;
        int         k;
        br_pat  = 6'b101101;
        hit_pat = 6'b100101;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i >= 2 && i <= 7) begin
                k = i - 2;
                n_cmp++; if (ret_valid !== 1'b1 || ret_tag !== 4'(k)) begin n_bad++; $display("FAIL br_ret[%0d]: got v=%b tag=%0d want v=1 tag=%0d", i, ret_valid, ret_tag, k); end
                n_cmp++; if (ret_wr_reg !== ~br_pat[k]) begin n_bad++; $display("FAIL br_wr_reg[%0d]: got %b want %b", i, ret_wr_reg, ~br_pat[k]); end
            end
            clear_offers();
            if (i < 6) offer(0, i, ~br_pat[i], i + 1, 32'h200 + i, br_pat[i], hit_pat[i]);
        end
        n_cmp++; if (retired_cnt !== 32'd6) begin n_bad++; $display("FAIL br_retired_cnt: got %0d want 6", retired_cnt); end
        n_cmp++; if (branch_cnt !== 32'd4) begin n_bad++; $display("FAIL br_branch_cnt: got %0d want 4", branch_cnt); end
        n_cmp++; if (hit_cnt !== 32'd3) begin n_bad++; $display("FAIL br_hit_cnt: got %0d want 3", hit_cnt); end
        n_cmp++; if (ret_valid !== 1'b0 || ret_wr_reg !== 1'b0) begin n_bad++; $display("FAIL br_idle: got v=%b wr=%b want 0 0", ret_valid, ret_wr_reg); end
        n_cmp++; if (ret_value !== 32'h205 || ret_rd !== 5'd6) begin n_bad++; $display("FAIL br_hold: got val=%h rd=%0d want 205 6", ret_value, ret_rd); end
    endtask

    task automatic test_flush();
        do_reset();
        @(negedge clk);
        flush = 1'b1; flush_tag = 4'd2;
        @(negedge clk);
        flush = 1'b0;
        offer(0, 3, 1'b1, 3, 32'h33, 1'b0, 1'b0);
        offer(1, 4, 1'b1, 4, 32'h44, 1'b0, 1'b0);
        #1;
        n_cmp++; if (wb_ready !== 2'b11) begin n_bad++; $display("FAIL flush_fill_ready: got %b want 11", wb_ready); end
        @(negedge clk);
        clear_offers();
        flush = 1'b1; flush_tag = 4'd9;
        offer(0, 9, 1'b1, 9, 32'hDEAD, 1'b0, 1'b0);
        #1;
        n_cmp++; if (wb_ready !== 2'b00) begin n_bad++; $display("FAIL flush_discard_ready: got %b want 00", wb_ready); end
        @(negedge clk);
        flush = 1'b0;
        clear_offers();
        n_cmp++; if (ret_valid !== 1'b0) begin n_bad++; $display("FAIL flush_ret_valid: got %b want 0", ret_valid); end
        offer(0, 9, 1'b1, 9, 32'h99, 1'b0, 1'b0);
        offer(1, 11, 1'b1, 11, 32'hBB, 1'b0, 1'b0);
        #1;
        n_cmp++; if (wb_ready !== 2'b11) begin n_bad++; $display("FAIL flush_slots_empty: got %b want 11", wb_ready); end
        @(negedge clk);
        clear_offers();
        n_cmp++; if (ret_valid !== 1'b0) begin n_bad++; $display("FAIL flush_no_stale: got %b want 0", ret_valid); end
        @(negedge clk);
        n_cmp++; if (ret_valid !== 1'b1 || ret_tag !== 4'd9 || ret_value !== 32'h99) begin n_bad++; $display("FAIL flush_ret9: got v=%b tag=%0d val=%h want v=1 tag=9 val=99", ret_valid, ret_tag, ret_value); end
        n_cmp++; if (retired_cnt !== 32'd1 || dup_err !== 1'b0) begin n_bad++; $display("FAIL flush_cnt: got cnt=%0d dup=%b want 1 0", retired_cnt, dup_err); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        @(negedge clk);
        offer(0, 0, 1'b1, 1, 32'h77, 1'b0, 1'b0);
        @(negedge clk);
        clear_offers();
        offer(0, 1, 1'b1, 2, 32'h78, 1'b0, 1'b0);
        @(negedge clk);
        clear_offers();
        n_cmp++; if (ret_valid !== 1'b1 || ret_value !== 32'h77) begin n_bad++; $display("FAIL midrst_pre: got v=%b val=%h want 1 77", ret_valid, ret_value); end
        #1;
        reset = 1'b0;
        #1;
        n_cmp++; if (ret_valid !== 1'b0 || ret_value !== 32'd0 || retired_cnt !== 32'd0) begin n_bad++; $display("FAIL midrst_async: got v=%b val=%h cnt=%0d want 0 0 0", ret_valid, ret_value, retired_cnt); end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (ret_valid !== 1'b0 || retired_cnt !== 32'd0) begin n_bad++; $display("FAIL midrst_lost: got v=%b cnt=%0d want 0 0", ret_valid, retired_cnt); end
    endtask

    initial begin
        clear_offers();
        flush     = 1'b0;
        flush_tag = '0;
        reset     = 1'b0;
        test_reset();
        test_in_order();
        test_out_of_order();
        test_collision();
        test_wrap();
        test_branches();
        test_flush();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
